matrix_gen_engine: RTL and testbench

//  Parametrised random-matrix generator for the UART command path. Takes ASCII digits for
//  m, n and count, then fills each matrix from a 16-bit LFSR with rejection-sampled elements.

---
 rtl/matrix_gen_if.sv | 22 ++
 rtl/matrix_gen_engine.sv | 255 +++++++++++++++++++++++++
 tb/tb_matrix_gen_engine.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_gen_if.sv
// Matrix offer port: flat row-major matrix plus its shape and index, handed over on a valid/ready handshake.
interface matrix_gen_if #(
    parameter int MAX_DIM = 5,
    parameter int ELEM_W  = 8
);
    logic [MAX_DIM*MAX_DIM*ELEM_W-1:0] out_matrix_flat;
    logic [3:0]                        out_m;
    logic [3:0]                        out_n;
    logic [3:0]                        out_idx;
    logic                              out_valid;
    logic                              out_ready;

    modport master (
        output out_matrix_flat, out_m, out_n, out_idx, out_valid,
        input  out_ready
    );

    modport slave (
        input  out_matrix_flat, out_m, out_n, out_idx, out_valid,
        output out_ready
    );
endinterface

// File: rtl/matrix_gen_engine.sv
// Random-matrix generator: takes ASCII m, n, count, fills matrices from a 16-bit LFSR by rejection sampling.
// Optional per-command element range (lo, hi digits) enabled by defining GEN_RANGE_CMD_EN.
module matrix_gen_engine #(
    parameter int          MAX_DIM   = 5,
    parameter int          ELEM_W    = 8,
    parameter int          MAX_NUM   = 4,
    parameter int          ELEM_MIN  = 0,
    parameter int          ELEM_MAX  = 9,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [7:0]        uart_data_i,
    input  logic              uart_data_valid_i,
    matrix_gen_if.master      bus,
    output logic              busy_o,
    output logic              gen_done_o,
    output logic              error_o,
    output logic [1:0]        err_code_o
);

    localparam int FLAT_W = MAX_DIM * MAX_DIM * ELEM_W;
    localparam int SPAN   = ELEM_MAX - ELEM_MIN;
    localparam int CW     = ($clog2(SPAN + 1) < 1) ? 1 : $clog2(SPAN + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_RX_M, S_RX_N, S_RX_NUM, S_RX_LO, S_RX_HI,
        S_FILL, S_PRESENT, S_DONE, S_ERR
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_DIM   = 2'd1,
        ERR_COUNT = 2'd2,
        ERR_DIGIT = 2'd3
    } err_e;

    state_e              state_q, state_d;
    err_e                err_code_q, err_code_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic [3:0]          m_q, m_d, n_q, n_d, num_q, num_d, idx_q, idx_d;
    logic [3:0]          i_q, i_d, j_q, j_d;
    logic [FLAT_W-1:0]   flat_q, flat_d;
    logic [ELEM_W-1:0]   range_lo, range_hi;

`ifdef GEN_RANGE_CMD_EN
    logic [ELEM_W-1:0]   lo_q, lo_d, hi_q, hi_d;
    assign range_lo = lo_q;
    assign range_hi = hi_q;
`else
    assign range_lo = ELEM_W'(ELEM_MIN);
    assign range_hi = ELEM_W'(ELEM_MAX);
`endif

    // Byte decode: for ASCII digits the low nibble is already the value.
    logic       digit_ok, dim_ok, count_ok;
    logic [3:0] digit;
    assign digit_ok = (uart_data_i >= 8'h30) && (uart_data_i <= 8'h39);
    assign digit    = uart_data_i[3:0];
    assign dim_ok   = (digit != 4'd0) && (int'(digit) <= MAX_DIM);
    assign count_ok = (digit != 4'd0) && (int'(digit) <= MAX_NUM);

    logic [CW-1:0]     cand;
    logic              cand_ok;
    logic [ELEM_W-1:0] elem_val;
    int                wr_idx;
    assign cand     = lfsr_q[CW-1:0];
    assign cand_ok  = ELEM_W'(cand) <= (range_hi - range_lo);
    assign elem_val = range_lo + ELEM_W'(cand);
    assign wr_idx   = int'(i_q) * int'(n_q) + int'(j_q);

    logic enter_fill;

    always_comb begin
        // NOTE: every next-state variable is defaulted first so no path can infer a latch.
        state_d    = state_q;
        err_code_d = err_code_q;
        lfsr_d     = lfsr_q;
        m_d        = m_q;
        n_d        = n_q;
        num_d      = num_q;
        idx_d      = idx_q;
        i_d        = i_q;
        j_d        = j_q;
        flat_d     = flat_q;
        enter_fill = 1'b0;
`ifdef GEN_RANGE_CMD_EN
        lo_d       = lo_q;
        hi_d       = hi_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    err_code_d = ERR_NONE;
                    state_d    = S_RX_M;
                end
            end
            S_RX_M: begin
                if (uart_data_valid_i) begin
                    if (!digit_ok) begin
                        err_code_d = ERR_DIGIT;
                        state_d    = S_ERR;
                    end else if (!dim_ok) begin
                        err_code_d = ERR_DIM;
                        state_d    = S_ERR;
                    end else begin
                        m_d     = digit;
                        state_d = S_RX_N;
                    end
                end
            end
            S_RX_N: begin
                if (uart_data_valid_i) begin
                    if (!digit_ok) begin
                        err_code_d = ERR_DIGIT;
                        state_d    = S_ERR;
                    end else if (!dim_ok) begin
                        err_code_d = ERR_DIM;
                        state_d    = S_ERR;
                    end else begin
                        n_d     = digit;
                        state_d = S_RX_NUM;
                    end
                end
            end
            S_RX_NUM: begin
                if (uart_data_valid_i) begin
                    if (!digit_ok) begin
                        err_code_d = ERR_DIGIT;
                        state_d    = S_ERR;
                    end else if (!count_ok) begin
                        err_code_d = ERR_COUNT;
                        state_d    = S_ERR;
                    end else begin
                        num_d = digit;
                        idx_d = 4'd0;
`ifdef GEN_RANGE_CMD_EN
                        state_d = S_RX_LO;
`else
                        state_d    = S_FILL;
                        enter_fill = 1'b1;
`endif
                    end
                end
            end
`ifdef GEN_RANGE_CMD_EN
            S_RX_LO: begin
                if (uart_data_valid_i) begin
                    if (!digit_ok || int'(digit) < ELEM_MIN || int'(digit) > ELEM_MAX) begin
                        err_code_d = ERR_DIGIT;
                        state_d    = S_ERR;
                    end else begin
                        lo_d    = ELEM_W'(digit);
                        state_d = S_RX_HI;
                    end
                end
            end
            S_RX_HI: begin
                if (uart_data_valid_i) begin
                    if (!digit_ok || ELEM_W'(digit) < lo_q || int'(digit) > ELEM_MAX) begin
                        err_code_d = ERR_DIGIT;
                        state_d    = S_ERR;
                    end else begin
                        hi_d       = ELEM_W'(digit);
                        state_d    = S_FILL;
                        enter_fill = 1'b1;
                    end
                end
            end
`endif
            S_FILL: begin
                lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
                if (cand_ok) begin
                    for (int k = 0; k < MAX_DIM * MAX_DIM; k++) begin
                        if (k == wr_idx) flat_d[k*ELEM_W +: ELEM_W] = elem_val;
                    end
                    if (j_q == n_q - 4'd1) begin
                        j_d = 4'd0;
                        if (i_q == m_q - 4'd1) state_d = S_PRESENT;
                        else                   i_d     = i_q + 4'd1;
                    end else begin
                        j_d = j_q + 4'd1;
                    end
                end
            end
            S_PRESENT: begin
                if (bus.out_ready) begin
                    if (idx_q == num_q - 4'd1) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d      = idx_q + 4'd1;
                        state_d    = S_FILL;
                        enter_fill = 1'b1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_RX_M;
            default: state_d = S_IDLE;
        endcase

        if (enter_fill) begin
            flat_d = '0;
            i_d    = 4'd0;
            j_d    = 4'd0;
        end
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            err_code_q <= ERR_NONE;
            lfsr_q     <= LFSR_SEED;
            m_q        <= 4'd0;
            n_q        <= 4'd0;
            num_q      <= 4'd0;
            idx_q      <= 4'd0;
            i_q        <= 4'd0;
            j_q        <= 4'd0;
            flat_q     <= '0;
`ifdef GEN_RANGE_CMD_EN
            lo_q       <= ELEM_W'(ELEM_MIN);
            hi_q       <= ELEM_W'(ELEM_MAX);
`endif
        end else begin
            state_q    <= state_d;
            err_code_q <= err_code_d;
            lfsr_q     <= lfsr_d;
            m_q        <= m_d;
            n_q        <= n_d;
            num_q      <= num_d;
            idx_q      <= idx_d;
            i_q        <= i_d;
            j_q        <= j_d;
            flat_q     <= flat_d;
`ifdef GEN_RANGE_CMD_EN
            lo_q       <= lo_d;
            hi_q       <= hi_d;
`endif
        end
    end

    assign bus.out_matrix_flat = flat_q;
    assign bus.out_m           = m_q;
    assign bus.out_n           = n_q;
    assign bus.out_idx         = idx_q;
    assign bus.out_valid       = (state_q == S_PRESENT);
    assign busy_o              = (state_q == S_FILL) || (state_q == S_PRESENT);
    assign gen_done_o          = (state_q == S_DONE);
    assign error_o             = (state_q == S_ERR);
    assign err_code_o          = err_code_q;

endmodule

// File: tb/tb_matrix_gen_engine.sv
// Directed bench for matrix_gen_engine with an LFSR reference model feeding a matrix scoreboard.
module tb_matrix_gen_engine;

    localparam int          MAX_DIM = 5;
    localparam int          ELEM_W  = 8;
    localparam int          FLAT_W  = MAX_DIM * MAX_DIM * ELEM_W;
    localparam int          CW      = 4;
    localparam logic [15:0] SEED    = 16'hACE1;
    localparam int          BUDGET  = 3000;

    typedef struct {
        logic [FLAT_W-1:0] flat;
        logic [3:0]        m;
        logic [3:0]        n;
        logic [3:0]        idx;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] uart_data = 8'h00;
    logic       uart_data_valid = 1'b0;
    logic       busy, gen_done, error;
    logic [1:0] err_code;

    matrix_gen_if #(.MAX_DIM(MAX_DIM), .ELEM_W(ELEM_W)) mgi ();

    matrix_gen_engine #(.MAX_DIM(MAX_DIM), .ELEM_W(ELEM_W)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start_i           (start),
        .uart_data_i       (uart_data),
        .uart_data_valid_i (uart_data_valid),
        .bus               (mgi),
        .busy_o            (busy),
        .gen_done_o        (gen_done),
        .error_o           (error),
        .err_code_o        (err_code)
    );

    always #5 clk = ~clk;

    int          pass_cnt = 0;
    int          fail_cnt = 0;
    int          total_cnt = 0;
    logic [15:0] model_lfsr = SEED;
    exp_t        sb_q[$];

    task automatic check(input string tag, input logic [FLAT_W-1:0] obs, input logic [FLAT_W-1:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        uart_data       = b;
        uart_data_valid = 1'b1;
        tick();
        uart_data_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Expected matrix from the spec's rejection sampler; the model LFSR steps once per FILL cycle.
    task automatic push_matrix(input int m, input int n, input int idx, input int lo, input int hi);
        exp_t        e;
        logic [15:0] nxt;
        int          c;
        bit          acc;
        e.flat = '0;
        for (int k = 0; k < m * n; k++) begin
            do begin
                c   = int'(model_lfsr[CW-1:0]);
                acc = (c <= hi - lo);
                nxt = {model_lfsr[14:0], model_lfsr[15] ^ model_lfsr[13] ^ model_lfsr[12] ^ model_lfsr[10]};
                model_lfsr = nxt;
            end while (!acc);
            e.flat[k*ELEM_W +: ELEM_W] = ELEM_W'(lo + c);
        end
        e.m   = 4'(m);
        e.n   = 4'(n);
        e.idx = 4'(idx);
        sb_q.push_back(e);
    endtask

    task automatic send_cmd(input int m, input int n, input int cnt);
        pulse_start();
        send_byte(8'(8'h30 + m));
        send_byte(8'(8'h30 + n));
        send_byte(8'(8'h30 + cnt));
`ifdef GEN_RANGE_CMD_EN
        send_byte(8'h30);
        send_byte(8'h39);
`endif
        for (int k = 0; k < cnt; k++) push_matrix(m, n, k, 0, 9);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (mgi.out_valid !== 1'b1 && n < BUDGET) begin
            tick();
            n++;
        end
        check({tag, "_valid_wait"}, mgi.out_valid, 1'b1);
    endtask

    task automatic wait_transfer(input string tag, input bit last);
        exp_t e;
        int   n = 0;
        while (!(mgi.out_valid === 1'b1 && mgi.out_ready === 1'b1) && n < BUDGET) begin
            tick();
            n++;
        end
        check({tag, "_xfer_wait"}, mgi.out_valid, 1'b1);
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 1'b0, 1'b1);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_flat"}, mgi.out_matrix_flat, e.flat);
            check({tag, "_m"},    mgi.out_m,   e.m);
            check({tag, "_n"},    mgi.out_n,   e.n);
            check({tag, "_idx"},  mgi.out_idx, e.idx);
            check({tag, "_busy"}, busy,        1'b1);
        end
        tick();
        check({tag, "_valid_drop"}, mgi.out_valid, 1'b0);
        if (last) begin
            check({tag, "_done_pulse"}, gen_done, 1'b1);
            tick();
            check({tag, "_done_low"}, gen_done, 1'b0);
            check({tag, "_idle_busy"}, busy, 1'b0);
        end else begin
            check({tag, "_no_done"}, gen_done, 1'b0);
            check({tag, "_refill_busy"}, busy, 1'b1);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_flat"},     mgi.out_matrix_flat, '0);
        check({tag, "_valid"},    mgi.out_valid, 1'b0);
        check({tag, "_m"},        mgi.out_m, 4'd0);
        check({tag, "_n"},        mgi.out_n, 4'd0);
        check({tag, "_idx"},      mgi.out_idx, 4'd0);
        check({tag, "_busy"},     busy, 1'b0);
        check({tag, "_gen_done"}, gen_done, 1'b0);
        check({tag, "_error"},    error, 1'b0);
        check({tag, "_err_code"}, err_code, 2'd0);
    endtask

    initial begin
        logic [FLAT_W-1:0] held_flat;
        bit                stable;

        mgi.out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick();
        check_idle("reset");
        rst_n = 1'b1;
        tick();

        // 2x3, single matrix, sink always ready; slots 6..24 must stay zero.
        mgi.out_ready = 1'b1;
        send_cmd(2, 3, 1);
        wait_transfer("m2x3", 1'b1);

        // 3x3 x2 with the sink stalled for 50 cycles after the first offer.
        mgi.out_ready = 1'b0;
        send_cmd(3, 3, 2);
        wait_valid("stall");
        held_flat = sb_q[0].flat;
        stable = 1'b1;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (mgi.out_valid !== 1'b1 || mgi.out_matrix_flat !== held_flat || mgi.out_idx !== 4'd0)
                stable = 1'b0;
        end
        check("stall_stable", stable, 1'b1);
        check("stall_idx", mgi.out_idx, 4'd0);
        mgi.out_ready = 1'b1;
        wait_transfer("stall_m0", 1'b0);
        wait_transfer("stall_m1", 1'b1);

        // Bad m, then recover from RX_M without a new start.
        pulse_start();
        send_byte(8'h36);
        check("bad_m_error", error, 1'b1);
        check("bad_m_code", err_code, 2'd1);
        tick();
        check("bad_m_error_pulse", error, 1'b0);
        check("bad_m_code_held", err_code, 2'd1);
        check("bad_m_not_busy", busy, 1'b0);
        send_byte(8'h31);
        send_byte(8'h31);
        send_byte(8'h31);
`ifdef GEN_RANGE_CMD_EN
        send_byte(8'h30);
        send_byte(8'h39);
`endif
        push_matrix(1, 1, 0, 0, 9);
        wait_transfer("m1x1", 1'b1);
        check("m1x1_code_held", err_code, 2'd1);

        // Non-digit, bad n, then bad count (start in RX_M is ignored).
        pulse_start();
        check("start_clears_code", err_code, 2'd0);
        send_byte(8'h41);
        check("nondigit_code", err_code, 2'd3);
        check("nondigit_error", error, 1'b1);
        tick();
        send_byte(8'h33);
        send_byte(8'h37);
        check("bad_n_code", err_code, 2'd1);
        tick();
        pulse_start();
        send_byte(8'h32);
        send_byte(8'h32);
        send_byte(8'h30);
        check("bad_count_code", err_code, 2'd2);
        check("bad_count_error", error, 1'b1);

        // Clean reset, then reset during the second fill; the rerun must reproduce from the seed.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_lfsr = SEED;
        sb_q.delete();
        tick();
        send_cmd(2, 2, 2);
        wait_transfer("pre_rst_m0", 1'b0);
        rst_n = 1'b0;
        tick();
        check_idle("mid_fill_rst");
        rst_n = 1'b1;
        model_lfsr = SEED;
        sb_q.delete();
        tick();
        send_cmd(2, 2, 2);
        wait_transfer("rerun_m0", 1'b0);
        wait_transfer("rerun_m1", 1'b1);

        // Largest accepted shape fills the whole bus.
        send_cmd(5, 5, 1);
        wait_transfer("m5x5", 1'b1);

`ifdef GEN_RANGE_CMD_EN
        pulse_start();
        send_byte(8'h32);
        send_byte(8'h32);
        send_byte(8'h31);
        send_byte(8'h37);
        send_byte(8'h37);
        push_matrix(2, 2, 0, 7, 7);
        wait_transfer("range77", 1'b1);
        pulse_start();
        send_byte(8'h32);
        send_byte(8'h32);
        send_byte(8'h31);
        send_byte(8'h38);
        send_byte(8'h33);
        check("range_bad_code", err_code, 2'd3);
        check("range_bad_error", error, 1'b1);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
